// File: rtl/rsa_decryptor.sv
// RSA receive side: derives d = e^-1 mod lamda by iterative extended Euclid,
// then recovers plain = cipher^d mod n by LSB-first square-and-multiply.
module rsa_decryptor #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] lamda,
    input  logic [W-1:0] e_key,
    input  logic [W-1:0] n_mod,
    input  logic [W-1:0] cipher,
    output logic         ready,
    output logic         out_valid,
    output logic [W-1:0] plain,
    output logic [W-1:0] d_key,
    output logic         error
);

    localparam int TW = W + 2;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK,
        S_INV,
        S_NORM,
        S_EXP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]         lam_q, lam_d;
    logic [W-1:0]         e_q, e_d;
    logic [W-1:0]         n_q, n_d;
    logic [W-1:0]         c_q, c_d;
    logic [W-1:0]         r0_q, r0_d;
    logic [W-1:0]         r1_q, r1_d;
    logic signed [TW-1:0] t0_q, t0_d;
    logic signed [TW-1:0] t1_q, t1_d;
    logic [W-1:0]         base_q, base_d;
    logic [W-1:0]         acc_q, acc_d;
    logic [W-1:0]         d_q, d_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [W-1:0]         plain_q, plain_d;
    logic [W-1:0]         dkey_q, dkey_d;
    logic                 error_q, error_d;

    logic [W-1:0]         quot, rem;
    logic signed [TW-1:0] t_step;
    logic signed [TW-1:0] norm_sum;
    logic [W-1:0]         acc_mul, base_sq;
    logic                 fin, fin_err;

    // Full 2W-bit product so nothing is lost before the modular reduction.
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] m);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        if (m == '0) return '0;
        return W'(p % {{W{1'b0}}, m});
    endfunction

    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d = state_q;
        lam_d   = lam_q;
        e_d     = e_q;
        n_d     = n_q;
        c_d     = c_q;
        r0_d    = r0_q;
        r1_d    = r1_q;
        t0_d    = t0_q;
        t1_d    = t1_q;
        base_d  = base_q;
        acc_d   = acc_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        plain_d = plain_q;
        dkey_d  = dkey_q;
        error_d = error_q;
        fin     = 1'b0;
        fin_err = 1'b0;
        quot    = '0;
        rem     = '0;

        if (r1_q != '0) begin
            quot = r0_q / r1_q;
            rem  = r0_q % r1_q;
        end
        t_step   = t0_q - signed'({2'b00, quot}) * t1_q;
        norm_sum = t0_q + signed'({2'b00, lam_q});
        acc_mul  = mulmod(acc_q, base_q, n_q);
        base_sq  = mulmod(base_q, base_q, n_q);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    lam_d   = lamda;
                    e_d     = e_key;
                    n_d     = n_mod;
                    c_d     = cipher;
                    state_d = S_CHK;
                end
            end
            S_CHK: begin
                if (lam_q < W'(2) || n_q < W'(2) || e_q == '0) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    r0_d    = lam_q;
                    r1_d    = e_q % lam_q;
                    t0_d    = '0;
                    t1_d    = TW'(1);
                    base_d  = c_q % n_q;
                    acc_d   = W'(1);
                    cnt_d   = '0;
                    state_d = S_INV;
                end
            end
            S_INV: begin
                if (r1_q == '0) begin
                    // e was a multiple of lamda: gcd is r0 itself.
                    fin     = (r0_q != W'(1));
                    fin_err = fin;
                    if (!fin) state_d = S_NORM;
                end else begin
                    r0_d = r1_q;
                    r1_d = rem;
                    t0_d = t1_q;
                    t1_d = t_step;
                    if (rem == '0) begin
                        fin     = (r1_q != W'(1));
                        fin_err = fin;
                        if (!fin) state_d = S_NORM;
                    end
                end
            end
            S_NORM: begin
                d_d     = W'(t0_q[TW-1] ? norm_sum : t0_q);
                state_d = S_EXP;
            end
            S_EXP: begin
                if (d_q[cnt_q]) acc_d = acc_mul;
                base_d = base_sq;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) fin = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Result registers load on the edge into DONE so they are valid with out_valid.
        if (fin) begin
            state_d = S_DONE;
            if (fin_err) begin
                plain_d = '0;
                dkey_d  = '0;
                error_d = 1'b1;
            end else begin
                plain_d = acc_d;
                dkey_d  = d_q;
                error_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            lam_q   <= '0;
            e_q     <= '0;
            n_q     <= '0;
            c_q     <= '0;
            r0_q    <= '0;
            r1_q    <= '0;
            t0_q    <= '0;
            t1_q    <= '0;
            base_q  <= '0;
            acc_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            plain_q <= '0;
            dkey_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lam_q   <= lam_d;
            e_q     <= e_d;
            n_q     <= n_d;
            c_q     <= c_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            base_q  <= base_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            plain_q <= plain_d;
            dkey_q  <= dkey_d;
            error_q <= error_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign plain     = plain_q;
    assign d_key     = dkey_q;
    assign error     = error_q;

endmodule

// File: tb/tb_rsa_decryptor.sv
// Directed bench for rsa_decryptor: key derivation, decryption, rejection,
// latency, back-to-back requests, busy-start rejection and mid-run reset.
module tb_rsa_decryptor;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] lamda, e_key, n_mod, cipher;
    logic       ready, out_valid, error;
    logic [7:0] plain, d_key;

    int checks = 0;
    int errors = 0;

    rsa_decryptor #(.W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .lamda    (lamda),
        .e_key    (e_key),
        .n_mod    (n_mod),
        .cipher   (cipher),
        .ready    (ready),
        .out_valid(out_valid),
        .plain    (plain),
        .d_key    (d_key),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issues one request and returns at the negedge of the out_valid cycle.
    // cyc counts cycles after acceptance (CHK = 1). inj_at>0 pulses a
    // foreign start with other operands in that cycle.
    task automatic run_req(input logic [7:0] l, input logic [7:0] e,
                           input logic [7:0] n, input logic [7:0] c,
                           input int inj_at, output int cyc, output logic rdy1);
        @(negedge clk);
        lamda = l; e_key = e; n_mod = n; cipher = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        rdy1  = ready;
        while (!out_valid && cyc < 60) begin
            if (cyc == inj_at) begin
                lamda = 8'd8; e_key = 8'd3; n_mod = 8'd15; cipher = 8'd13;
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL timeout: out_valid=%0b after %0d cycles, required 1", out_valid, cyc);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        lamda = '0; e_key = '0; n_mod = '0; cipher = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready, out_valid, error, plain, d_key} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_state: ready=%0b ov=%0b err=%0b plain=%0d d=%0d, required 1 0 0 0 0",
                     ready, out_valid, error, plain, d_key);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int cyc; logic rdy1;
        run_req(8'd40, 8'd3, 8'd55, 8'd8, 0, cyc, rdy1);
        checks++;
        if (rdy1 !== 1'b0) begin errors++; $display("FAIL t1_ready_drop: ready=%0b required 0", rdy1); end
        checks++;
        if (cyc != 13) begin errors++; $display("FAIL t1_latency: got %0d cycles, required 13", cyc); end
        checks++;
        if ({d_key, plain, error} !== {8'd27, 8'd2, 1'b0}) begin
            errors++;
            $display("FAIL t1_result: d=%0d plain=%0d err=%0b, required 27 2 0", d_key, plain, error);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, ready, plain} !== {1'b0, 1'b1, 8'd2}) begin
            errors++;
            $display("FAIL t1_pulse: ov=%0b ready=%0b plain=%0d, required 0 1 2", out_valid, ready, plain);
        end
    endtask

    task automatic test_back_to_back;
        int cyc; logic rdy1;
        run_req(8'd8, 8'd3, 8'd15, 8'd13, 0, cyc, rdy1);
        checks++;
        if ({d_key, plain, error} !== {8'd3, 8'd7, 1'b0} || cyc != 14) begin
            errors++;
            $display("FAIL t2_first: d=%0d plain=%0d err=%0b cyc=%0d, required 3 7 0 14",
                     d_key, plain, error, cyc);
        end
        run_req(8'd8, 8'd3, 8'd15, 8'd0, 0, cyc, rdy1);
        checks++;
        if ({d_key, plain, error} !== {8'd3, 8'd0, 1'b0} || cyc != 14) begin
            errors++;
            $display("FAIL t2_zero_cipher: d=%0d plain=%0d err=%0b cyc=%0d, required 3 0 0 14",
                     d_key, plain, error, cyc);
        end
    endtask

    task automatic test_errors;
        int cyc; logic rdy1;
        run_req(8'd40, 8'd4, 8'd55, 8'd8, 0, cyc, rdy1);
        checks++;
        if ({error, plain, d_key} !== {1'b1, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL t3_gcd: err=%0b plain=%0d d=%0d, required 1 0 0", error, plain, d_key);
        end
        run_req(8'd1, 8'd3, 8'd55, 8'd8, 0, cyc, rdy1);
        checks++;
        if (error !== 1'b1 || cyc != 2) begin
            errors++;
            $display("FAIL t3_lamda1: err=%0b cyc=%0d, required 1 2", error, cyc);
        end
        run_req(8'd40, 8'd3, 8'd1, 8'd8, 0, cyc, rdy1);
        checks++;
        if (error !== 1'b1 || cyc != 2) begin
            errors++;
            $display("FAIL t3_n1: err=%0b cyc=%0d, required 1 2", error, cyc);
        end
        run_req(8'd40, 8'd0, 8'd55, 8'd8, 0, cyc, rdy1);
        checks++;
        if (error !== 1'b1 || cyc != 2) begin
            errors++;
            $display("FAIL t3_e0: err=%0b cyc=%0d, required 1 2", error, cyc);
        end
        // e a multiple of lamda: r1 is 0 entering INV, one INV cycle then reject.
        run_req(8'd40, 8'd80, 8'd55, 8'd8, 0, cyc, rdy1);
        checks++;
        if (error !== 1'b1 || cyc != 3) begin
            errors++;
            $display("FAIL t3_e_mult: err=%0b cyc=%0d, required 1 3", error, cyc);
        end
    endtask

    task automatic test_reduce;
        int cyc; logic rdy1;
        run_req(8'd40, 8'd3, 8'd55, 8'd63, 0, cyc, rdy1);
        checks++;
        if ({plain, d_key, error} !== {8'd2, 8'd27, 1'b0}) begin
            errors++;
            $display("FAIL t4_reduce: plain=%0d d=%0d err=%0b, required 2 27 0", plain, d_key, error);
        end
    endtask

    task automatic test_reset_mid;
        int cyc; logic rdy1; int seen;
        @(negedge clk);
        lamda = 8'd40; e_key = 8'd3; n_mod = 8'd55; cipher = 8'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);   // now in cycle 7, inside EXP
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({ready, out_valid, error, plain, d_key} !== {1'b1, 1'b0, 1'b0, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL t5_reset: ready=%0b ov=%0b err=%0b plain=%0d d=%0d, required 1 0 0 0 0",
                     ready, out_valid, error, plain, d_key);
        end
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL t5_no_valid: %0d pulses, required 0", seen); end
        run_req(8'd40, 8'd3, 8'd55, 8'd8, 0, cyc, rdy1);
        checks++;
        if ({plain, d_key} !== {8'd2, 8'd27}) begin
            errors++;
            $display("FAIL t5_restart: plain=%0d d=%0d, required 2 27", plain, d_key);
        end
    endtask

    task automatic test_busy_start;
        int cyc; logic rdy1;
        run_req(8'd40, 8'd3, 8'd55, 8'd8, 3, cyc, rdy1);
        checks++;
        if ({d_key, plain, error} !== {8'd27, 8'd2, 1'b0} || cyc != 13) begin
            errors++;
            $display("FAIL t6_busy: d=%0d plain=%0d err=%0b cyc=%0d, required 27 2 0 13",
                     d_key, plain, error, cyc);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, ready} !== {1'b0, 1'b1}) begin
            errors++;
            $display("FAIL t6_idle: ov=%0b ready=%0b, required 0 1", out_valid, ready);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_errors;
        test_reduce;
        test_reset_mid;
        test_busy_start;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
